// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and helpers for the VGA pixel pipeline.
// Imported by the timing generator and by the pixel colouring / apple logic.
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned VGA_CLK_DIV = 4;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit SYNC_ACTIVE_LOW = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // Level to drive on a sync pin given whether the pulse is active.
  function automatic logic sync_level(input logic in_sync, input bit pol);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel interface between the timing source and the pixel colouring logic.
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  logic   de;
  logic   hsync;
  logic   vsync;
  logic   pix_en;
  logic   line_tick;
  logic   frame_tick;

  modport master (
    output x, y, de, hsync, vsync, pix_en, line_tick, frame_tick
  );

  modport slave (
    input x, y, de, hsync, vsync, pix_en, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus decode of the value it takes on this edge,
// so the parent can register active/sync alongside the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = VGA_H_TOTAL,
  parameter int unsigned ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
  parameter int unsigned SYNC_END   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t count,
  output logic   wrap_c,
  output logic   active_c,
  output logic   in_sync_c
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END = coord_t'(ACTIVE);
  localparam coord_t SYN_BEG = coord_t'(SYNC_START);
  localparam coord_t SYN_END = coord_t'(SYNC_END);

  coord_t count_nxt;

  // Next value and its decode; holds when not incrementing.
  always_comb begin
    wrap_c    = inc && (count == LAST);
    count_nxt = count;
    if (inc) begin
      count_nxt = wrap_c ? '0 : count + coord_t'(1);
    end
    active_c  = (count_nxt < ACT_END);
    in_sync_c = (count_nxt >= SYN_BEG) && (count_nxt < SYN_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: divides the system clock to the pixel rate, runs h/v counters
// and drives registered sync, data-enable, coordinates and line/frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t      V_LAST_ACTIVE = coord_t'(V_ACTIVE - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the coordinate width");
  end

  logic   pix_en_int;
  coord_t h_count;
  coord_t v_count;
  logic   h_wrap_c;
  logic   h_active_c;
  logic   h_sync_c;
  logic   v_wrap_c;
  logic   v_active_c;
  logic   v_sync_c;
  logic   unused_v_wrap;

  logic de_q;
  logic hsync_q;
  logic vsync_q;
  logic pix_en_q;
  logic line_tick_q;
  logic frame_tick_q;

  // Pixel-rate prescaler; the enable fires on the last sys clock of each pixel.
  if (CLK_DIV == 1) begin : g_no_div
    assign pix_en_int = 1'b1;
  end else begin : g_div
    localparam int unsigned PS_W    = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    logic [PS_W-1:0] prescale;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prescale <= '0;
      end else if (prescale == PS_LAST) begin
        prescale <= '0;
      end else begin
        prescale <= prescale + PS_W'(1);
      end
    end

    assign pix_en_int = (prescale == PS_LAST);
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (pix_en_int),
    .count     (h_count),
    .wrap_c    (h_wrap_c),
    .active_c  (h_active_c),
    .in_sync_c (h_sync_c)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (h_wrap_c),
    .count     (v_count),
    .wrap_c    (v_wrap_c),
    .active_c  (v_active_c),
    .in_sync_c (v_sync_c)
  );

  // Frame wrap coincides with a line wrap, so it needs no separate strobe.
  assign unused_v_wrap = v_wrap_c;

  // Decode registered from next counter values so it lines up with x/y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q         <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      pix_en_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_en_q     <= pix_en_int;
      line_tick_q  <= h_wrap_c;
      frame_tick_q <= h_wrap_c && (v_count == V_LAST_ACTIVE);
      if (pix_en_int) begin
        de_q    <= h_active_c && v_active_c;
        hsync_q <= sync_level(h_sync_c, SYNC_POL);
        vsync_q <= sync_level(v_sync_c, SYNC_POL);
      end
    end
  end

  assign vga.x          = h_count;
  assign vga.y          = v_count;
  assign vga.de         = de_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.pix_en     = pix_en_q;
  assign vga.line_tick  = line_tick_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 at CLK_DIV 4 and 1, plus a shrunken
// geometry so whole frames fit in a short run; outputs checked every clock.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rsta = 1'b0;
  logic rstb = 1'b0;
  logic rstc = 1'b0;
  logic chk_en = 1'b0;
  int unsigned ka = 0;
  int unsigned kb = 0;
  int unsigned kc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen u_a (.clk(clk), .rst_n(rsta), .vga(ifa));

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_b (.clk(clk), .rst_n(rstb), .vga(ifb));

  vga_timing_gen #(.CLK_DIV(1)) u_c (.clk(clk), .rst_n(rstc), .vga(ifc));

  // Edges seen since reset release, per DUT.
  always @(posedge clk) begin
    ka <= rsta ? ka + 1 : 0;
    kb <= rstb ? kb + 1 : 0;
    kc <= rstc ? kc + 1 : 0;
  end

  // Packed view: {x[25:16], y[15:6], de, hsync, vsync, pix_en, line_tick, frame_tick}
  function automatic logic [25:0] vec(input int d);
    case (d)
      0: return {ifa.x, ifa.y, ifa.de, ifa.hsync, ifa.vsync, ifa.pix_en, ifa.line_tick, ifa.frame_tick};
      1: return {ifb.x, ifb.y, ifb.de, ifb.hsync, ifb.vsync, ifb.pix_en, ifb.line_tick, ifb.frame_tick};
      default: return {ifc.x, ifc.y, ifc.de, ifc.hsync, ifc.vsync, ifc.pix_en, ifc.line_tick, ifc.frame_tick};
    endcase
  endfunction

  // Expected outputs after k edges: pixel index p = k/div locates (h,v) in raster order.
  function automatic logic [25:0] model(input int unsigned k, input int unsigned div,
      input int unsigned ha, input int unsigned hfp, input int unsigned hsw, input int unsigned hbp,
      input int unsigned va, input int unsigned vfp, input int unsigned vsw, input int unsigned vbp);
    int unsigned p, ht, vt, h, v;
    logic de, hs, vs, pe, lt, ft;
    p = k / div;
    if (p == 0) return {20'd0, 6'b011000};
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    de = (h < ha) && (v < va);
    hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    vs = !((v >= va + vfp) && (v < va + vfp + vsw));
    pe = (k % div) == 0;
    lt = pe && (h == 0);
    ft = lt && (v == va);
    return {10'(h), 10'(v), de, hs, vs, pe, lt, ft};
  endfunction

  function automatic logic [25:0] expvec(input int d);
    case (d)
      0: return model(ka, 4, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                      VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
      1: return model(kb, 4, 16, 2, 4, 3, 12, 2, 2, 3);
      default: return model(kc, 1, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                            VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    endcase
  endfunction

  task automatic check_vec(input string name, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b (t=%0t)",
               name, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0], $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Every-cycle comparison against the raster model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("model_a", vec(0), expvec(0));
      check_vec("model_b", vec(1), expvec(1));
      check_vec("model_c", vec(2), expvec(2));
    end
  end

  task automatic wait_bit(input int d, input int b, input int limit, output int n);
    logic [25:0] v;
    n = 0;
    v = vec(d);
    while (!v[b] && n < limit) begin
      @(negedge clk);
      n++;
      v = vec(d);
    end
    if (!v[b]) timeout("wait_bit");
  endtask

  task automatic wait_xy(input int d, input int x, input int y, input int limit);
    logic [25:0] v;
    int n;
    n = 0;
    v = vec(d);
    while (!(int'(v[25:16]) == x && (y < 0 || int'(v[15:6]) == y)) && n < limit) begin
      @(negedge clk);
      n++;
      v = vec(d);
    end
    if (n >= limit) timeout("wait_xy");
  endtask

  task automatic strobe_gap(input int d, input int b, input int limit, output int gap);
    int n;
    wait_bit(d, b, limit, n);
    @(negedge clk);
    wait_bit(d, b, limit, n);
    gap = n + 1;
  endtask

  // One line of pixels starting at a line_tick: hsync low span and de count.
  task automatic line_scan(input int d, input int total, output int hs_cnt,
                           output int first, output int last, output int de_cnt);
    logic [25:0] v;
    int n;
    hs_cnt = 0; first = -1; last = -1; de_cnt = 0;
    wait_bit(d, 1, 4 * VGA_H_TOTAL * 2, n);
    for (int i = 0; i < total; i++) begin
      if (i > 0) begin
        @(negedge clk);
        wait_bit(d, 2, 8, n);
      end
      v = vec(d);
      if (!v[4]) begin
        hs_cnt++;
        if (first < 0) first = int'(v[25:16]);
        last = int'(v[25:16]);
      end
      if (v[5]) de_cnt++;
    end
  endtask

  // One frame of lines: vsync low span by y.
  task automatic frame_scan(input int d, input int vtotal, output int vs_cnt,
                            output int first, output int last);
    logic [25:0] v;
    int n;
    vs_cnt = 0; first = -1; last = -1;
    for (int i = 0; i < vtotal; i++) begin
      if (i > 0) @(negedge clk);
      wait_bit(d, 1, 400, n);
      v = vec(d);
      if (!v[3]) begin
        vs_cnt++;
        if (first < 0) first = int'(v[15:6]);
        last = int'(v[15:6]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_a, first_c, gap, hs_cnt, hs_first, hs_last, de_cnt, n;
    logic [25:0] v;
    first_a = -1;
    first_c = -1;

    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rsta = 1'b1; rstb = 1'b1; rstc = 1'b1;

    @(negedge clk);
    check_vec("reset_a", vec(0), {20'd0, 6'b011000});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      v = vec(0);
      if (v[2] && first_a < 0) first_a = i;
      v = vec(2);
      if (v[2] && first_c < 0) first_c = i;
    end
    check_int("first_pix_en_a", first_a, 4);
    check_int("first_pix_en_c", first_c, 1);
    v = vec(0);
    check_int("x_after_first_pix_a", int'(v[25:16]), 1);

    strobe_gap(0, 1, 4000, gap);
    check_int("line_gap_a", gap, 3200);
    line_scan(0, 800, hs_cnt, hs_first, hs_last, de_cnt);
    check_int("hsync_len_a", hs_cnt, 96);
    check_int("hsync_first_a", hs_first, 656);
    check_int("hsync_last_a", hs_last, 751);
    check_int("de_len_a", de_cnt, 640);

    strobe_gap(1, 0, 2500, gap);
    check_int("frame_gap_b", gap, 1900);
    frame_scan(1, 19, hs_cnt, hs_first, hs_last);
    check_int("vsync_len_b", hs_cnt, 2);
    check_int("vsync_first_b", hs_first, 14);
    check_int("vsync_last_b", hs_last, 15);

    wait_xy(1, 24, 18, 2500);
    @(negedge clk);
    wait_bit(1, 2, 8, n);
    check_vec("frame_wrap_b", vec(1), {20'd0, 6'b111110});

    wait_xy(0, 300, -1, 4000);
    rsta = 1'b0;
    @(negedge clk);
    check_vec("midframe_reset_a", vec(0), {20'd0, 6'b011000});
    @(posedge clk);
    #1 rsta = 1'b1;
    strobe_gap(0, 1, 4000, gap);
    check_int("line_gap_after_reset_a", gap, 3200);

    strobe_gap(2, 1, 1000, gap);
    check_int("line_gap_c", gap, 800);
    line_scan(2, 800, hs_cnt, hs_first, hs_last, de_cnt);
    check_int("hsync_len_c", hs_cnt, 96);
    check_int("hsync_first_c", hs_first, 656);
    check_int("hsync_last_c", hs_last, 751);

    repeat (20) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
